// File: rtl/pp_pkg.sv
// Shared ball-state definitions: court length, direction encoding
// and the one-hot legality check, also reused by the score logic.
package pp_pkg;

  localparam int COURT_N = 6;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_t;

  // True when exactly one bit of v is set.
  // Callers zero-extend narrower state vectors.
  function automatic logic onehot_ok(input logic [31:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++)
      cnt += int'(v[i]);
    return cnt == 1;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary encoder with a legality flag.
// Ports: state (N one-hot bits) -> enc (index), legal (popcount==1).
module onehot_enc
  import pp_pkg::*;
#(
  parameter int N = COURT_N
) (
  input  logic [N-1:0]         state,
  output logic [$clog2(N)-1:0] enc,
  output logic                 legal
);

  localparam int PW = $clog2(N);

  // OR of set-bit indices; only meaningful when legal.
  always_comb begin
    enc = '0;
    for (int i = 0; i < N; i++)
      if (state[i])
        enc = enc | PW'(i);
    legal = onehot_ok(32'(state));
  end

endmodule

// File: rtl/onehot_pos_tracker.sv
// Samples the one-hot ball state, tracks position, direction, dwell
// and end-of-court bounces, and flags corrupt states or illegal jumps.
// Ports: CLK, RST (sync, active high), state in; pos, pos_vld, dir,
// step, bounce, dwell, err_onehot, err_jump, err_sticky out (registered).
module onehot_pos_tracker
  import pp_pkg::*;
#(
  parameter int N    = COURT_N,
  parameter int DW_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         state,
  output logic [$clog2(N)-1:0] pos,
  output logic                 pos_vld,
  output logic                 dir,
  output logic                 step,
  output logic                 bounce,
  output logic [DW_W-1:0]      dwell,
  output logic                 err_onehot,
  output logic                 err_jump,
  output logic                 err_sticky
);

  localparam int PW = $clog2(N);
  localparam logic [DW_W-1:0] DW_MAX = '1;
  localparam logic [PW:0] ONE = (PW+1)'(1);
  localparam logic [PW-1:0] LAST = PW'(N-1);

  logic [PW-1:0] enc;
  logic          legal;

  onehot_enc #(.N(N)) u_enc (
    .state (state),
    .enc   (enc),
    .legal (legal)
  );

  dir_t dir_q;
  dir_t dir_n;
  logic [PW-1:0]   pos_n;
  logic            vld_n;
  logic [DW_W-1:0] dwell_n;
  logic step_n;
  logic bounce_n;
  logic eoh_n;
  logic ejp_n;
  logic sticky_n;

  // Signed difference is one bit wider than pos so 0 <-> N-1
  // shows up as a large magnitude, never a wrapped neighbour.
  logic signed [PW:0] diff;
  logic [PW:0]        mag;
  logic same;
  logic adj;
  logic at_end;

  assign diff   = $signed({1'b0, enc}) - $signed({1'b0, pos});
  assign mag    = diff[PW] ? PW'(0) - diff : diff;
  assign same   = (diff == '0);
  assign adj    = (mag == ONE);
  assign at_end = (pos == '0) || (pos == LAST);

  always_comb begin
    pos_n    = pos;
    vld_n    = pos_vld;
    dir_n    = dir_q;
    dwell_n  = dwell;
    step_n   = 1'b0;
    bounce_n = 1'b0;
    eoh_n    = 1'b0;
    ejp_n    = 1'b0;
    unique case (1'b1)
      !legal: begin
        eoh_n = 1'b1;
        vld_n = 1'b0;
      end
      legal && !pos_vld: begin
        pos_n   = enc;
        vld_n   = 1'b1;
        dwell_n = '0;
      end
      legal && pos_vld && same: begin
        if (dwell != DW_MAX)
          dwell_n = dwell + 1'b1;
      end
      legal && pos_vld && adj: begin
        pos_n   = enc;
        step_n  = 1'b1;
        dwell_n = '0;
        dir_n   = diff[PW] ? DIR_DN : DIR_UP;
        // A reversal is only legal at either end of the court.
        if (dir_n != dir_q) begin
          if (at_end)
            bounce_n = 1'b1;
          else
            ejp_n = 1'b1;
        end
      end
      default: begin
        ejp_n   = 1'b1;
        pos_n   = enc;
        dwell_n = '0;
      end
    endcase
    sticky_n = err_sticky | eoh_n | ejp_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pos        <= '0;
      pos_vld    <= 1'b0;
      dir_q      <= DIR_UP;
      dwell      <= '0;
      step       <= 1'b0;
      bounce     <= 1'b0;
      err_onehot <= 1'b0;
      err_jump   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      pos        <= pos_n;
      pos_vld    <= vld_n;
      dir_q      <= dir_n;
      dwell      <= dwell_n;
      step       <= step_n;
      bounce     <= bounce_n;
      err_onehot <= eoh_n;
      err_jump   <= ejp_n;
      err_sticky <= sticky_n;
    end
  end

  assign dir = dir_q;

endmodule

// File: tb/tb_onehot_pos_tracker.sv
// Testbench for onehot_pos_tracker: directed scenarios plus a random
// walk, every cycle compared against an integer reference model.
module tb_onehot_pos_tracker;

  localparam int N    = 6;
  localparam int DW_W = 8;
  localparam int PW   = $clog2(N);
  localparam int DMAX = (1 << DW_W) - 1;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [N-1:0]    state = 6'b000001;
  logic [PW-1:0]   pos;
  logic            pos_vld;
  logic            dir;
  logic            step;
  logic            bounce;
  logic [DW_W-1:0] dwell;
  logic            err_onehot;
  logic            err_jump;
  logic            err_sticky;

  onehot_pos_tracker #(.N(N), .DW_W(DW_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .state      (state),
    .pos        (pos),
    .pos_vld    (pos_vld),
    .dir        (dir),
    .step       (step),
    .bounce     (bounce),
    .dwell      (dwell),
    .err_onehot (err_onehot),
    .err_jump   (err_jump),
    .err_sticky (err_sticky)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  int m_pos, m_dwell, m_dir;
  bit m_vld, m_step, m_bounce, m_eoh, m_ejp, m_sticky;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: court position as a plain integer, rules applied directly.
  task automatic model(input logic [N-1:0] s, input bit r);
    int e, d, nd;
    m_step = 0; m_bounce = 0; m_eoh = 0; m_ejp = 0;
    if (r) begin
      m_pos = 0; m_vld = 0; m_dir = 1; m_dwell = 0; m_sticky = 0;
      return;
    end
    if ($countones(s) != 1) begin
      m_eoh = 1;
      m_vld = 0;
    end else begin
      e = 0;
      for (int i = 0; i < N; i++)
        if (s[i]) e = i;
      if (!m_vld) begin
        m_pos = e; m_vld = 1; m_dwell = 0;
      end else begin
        d = e - m_pos;
        if (d == 0) begin
          m_dwell = (m_dwell < DMAX) ? m_dwell + 1 : DMAX;
        end else if (d == 1 || d == -1) begin
          nd = (d > 0) ? 1 : 0;
          m_step = 1;
          if (nd != m_dir) begin
            if (m_pos == 0 || m_pos == N - 1) m_bounce = 1;
            else m_ejp = 1;
          end
          m_dir = nd; m_pos = e; m_dwell = 0;
        end else begin
          m_ejp = 1; m_pos = e; m_dwell = 0;
        end
      end
    end
    m_sticky = m_sticky | m_eoh | m_ejp;
  endtask

  task automatic cyc(input logic [N-1:0] s, input bit r);
    @(negedge CLK);
    state = s;
    RST   = r;
    @(posedge CLK);
    model(s, r);
    #1;
    check("pos", int'(pos), m_pos);
    check("pos_vld", int'(pos_vld), int'(m_vld));
    check("dir", int'(dir), m_dir);
    check("step", int'(step), int'(m_step));
    check("bounce", int'(bounce), int'(m_bounce));
    check("dwell", int'(dwell), m_dwell);
    check("err_onehot", int'(err_onehot), int'(m_eoh));
    check("err_jump", int'(err_jump), int'(m_ejp));
    check("err_sticky", int'(err_sticky), int'(m_sticky));
  endtask

  function automatic logic [N-1:0] oh(input int p);
    return N'(1) << p;
  endfunction

  int bc;
  int rp;
  int rv;

  initial begin
    cyc(6'b000001, 1);
    cyc(6'b000001, 1);
    check("rst_dir", int'(dir), 1);
    check("rst_vld", int'(pos_vld), 0);

    cyc(6'b000001, 0);
    check("first_pos", int'(pos), 0);
    check("first_vld", int'(pos_vld), 1);
    check("first_step", int'(step), 0);

    for (int p = 1; p < N; p++) begin
      cyc(oh(p), 0);
      check("up_step", int'(step), 1);
    end
    bc = 0;
    for (int p = N - 2; p >= 0; p--) begin
      cyc(oh(p), 0);
      check("dn_step", int'(step), 1);
      bc += int'(bounce);
    end
    check("dn_dir", int'(dir), 0);
    check("bounce_once", bc, 1);
    cyc(oh(1), 0);
    check("bounce_low", int'(bounce), 1);

    cyc(6'b000100, 0);
    for (int i = 0; i < 300; i++)
      cyc(6'b000100, 0);
    check("hold_pos", int'(pos), 2);
    check("dwell_sat", int'(dwell), DMAX);

    cyc(6'b000011, 0);
    check("oh_err", int'(err_onehot), 1);
    check("oh_sticky", int'(err_sticky), 1);
    cyc(6'b001000, 0);
    check("oh_recover", int'(pos), 3);
    check("oh_nojump", int'(err_jump), 0);
    cyc(6'b001000, 0);
    check("oh_pulse", int'(err_onehot), 0);

    cyc(6'b000100, 0);
    cyc(6'b000010, 0);
    cyc(6'b010000, 0);
    check("jump_err", int'(err_jump), 1);
    check("jump_pos", int'(pos), 4);
    check("jump_dir", int'(dir), 0);

    cyc(6'b001000, 0);
    cyc(6'b000100, 0);
    cyc(6'b000010, 0);
    cyc(6'b000001, 0);
    cyc(6'b100000, 0);
    check("nowrap_err", int'(err_jump), 1);
    check("nowrap_pos", int'(pos), 5);

    cyc(6'b010000, 0);
    cyc(6'b001000, 0);
    cyc(6'b010000, 1);
    check("mrst_pos", int'(pos), 0);
    check("mrst_vld", int'(pos_vld), 0);
    check("mrst_sticky", int'(err_sticky), 0);

    rp = 0;
    for (int i = 0; i < 3000; i++) begin
      rv = $urandom_range(0, 99);
      if (rv < 60) begin
        if ($urandom_range(0, 1) == 1) rp = (rp < N - 1) ? rp + 1 : rp - 1;
        else rp = (rp > 0) ? rp - 1 : rp + 1;
        cyc(oh(rp), 0);
      end else if (rv < 78) begin
        cyc(oh(rp), 0);
      end else if (rv < 88) begin
        rp = $urandom_range(0, N - 1);
        cyc(oh(rp), 0);
      end else if (rv < 97) begin
        cyc(N'($urandom), 0);
      end else begin
        cyc(oh(rp), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
